// File: rtl/rv32_pkg.sv
// Shared types for the rv32 pipeline control slice.
// State encoding, redirect source constants, per-stage flag bundle.
package rv32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2,
        HALT       = 2'd3
    } pipe_ctrl_state_t;

    localparam logic REDIR_BRANCH = 1'b0;
    localparam logic REDIR_TRAP   = 1'b1;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_vec_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrapping 32-bit pipeline performance counters.
// Built only when PIPELINE_CTRL_PERF_EN is defined.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    input  logic        redirect,
    input  logic        halted,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_halt_cycles
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
            perf_halt_cycles  <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + 32'(pc_stall);
            perf_flush_count  <= perf_flush_count + 32'(redirect);
            perf_halt_cycles  <= perf_halt_cycles + 32'(halted);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller for the 5-stage rv32 pipeline.
// Optional counters: define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import rv32::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_busy,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        trap,
    input  logic        mem_busy,
    input  logic        wfi,
    input  logic        irq_pending,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_squash,
    output logic        id_ex_squash,
    output logic        ex_mem_squash,
    output logic        mem_wb_squash,
    output logic        redirect,
    output logic        redirect_sel
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_halt_cycles
`endif
);

    pipe_ctrl_state_t state_q, state_d;
    stage_vec_t       st, sq;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        st           = '0;
        sq           = '0;
        pc_stall     = 1'b0;
        redirect     = 1'b0;
        redirect_sel = REDIR_BRANCH;
        if (rst) begin
            sq      = '1;
            state_d = RUN;
        end else if (mem_busy) begin
            // EX is frozen, so its events are simply re-seen later
            pc_stall  = 1'b1;
            st.if_id  = 1'b1;
            st.id_ex  = 1'b1;
            st.ex_mem = 1'b1;
            sq.mem_wb = 1'b1;
            sq.if_id  = (state_q == TRAP_FLUSH);
            state_d   = MEM_WAIT;
        end else begin
            unique case (state_q)
                TRAP_FLUSH: begin
                    sq.if_id = 1'b1;
                    state_d  = RUN;
                end
                HALT: begin
                    if (irq_pending) begin
                        state_d = RUN;
                    end else begin
                        pc_stall  = 1'b1;
                        st.if_id  = 1'b1;
                        st.id_ex  = 1'b1;
                        sq.ex_mem = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    priority case (1'b1)
                        trap: begin
                            redirect     = 1'b1;
                            redirect_sel = REDIR_TRAP;
                            sq.if_id     = 1'b1;
                            sq.id_ex     = 1'b1;
                            sq.ex_mem    = 1'b1;
                            state_d      = TRAP_FLUSH;
                        end
                        branch_taken: begin
                            redirect = 1'b1;
                            sq.if_id = 1'b1;
                            sq.id_ex = 1'b1;
                        end
                        (wfi && !irq_pending): begin
                            pc_stall  = 1'b1;
                            st.if_id  = 1'b1;
                            st.id_ex  = 1'b1;
                            sq.ex_mem = 1'b1;
                            state_d   = HALT;
                        end
                        load_use: begin
                            pc_stall = 1'b1;
                            st.if_id = 1'b1;
                            sq.id_ex = 1'b1;
                        end
                        if_busy: begin
                            pc_stall = 1'b1;
                            sq.if_id = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign if_id_stall   = st.if_id  & ~sq.if_id;
    assign id_ex_stall   = st.id_ex  & ~sq.id_ex;
    assign ex_mem_stall  = st.ex_mem & ~sq.ex_mem;
    assign mem_wb_stall  = st.mem_wb & ~sq.mem_wb;
    assign if_id_squash  = sq.if_id;
    assign id_ex_squash  = sq.id_ex;
    assign ex_mem_squash = sq.ex_mem;
    assign mem_wb_squash = sq.mem_wb;

`ifdef PIPELINE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk               (clk),
        .rst               (rst),
        .pc_stall          (pc_stall),
        .redirect          (redirect),
        .halted            (state_q == HALT),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
        .perf_halt_cycles  (perf_halt_cycles)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table plus
// randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst, if_busy, load_use, branch_taken, trap;
    logic mem_busy, wfi, irq_pending;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic if_id_squash, id_ex_squash, ex_mem_squash, mem_wb_squash;
    logic redirect, redirect_sel;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count, perf_halt_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_busy       (if_busy),
        .load_use      (load_use),
        .branch_taken  (branch_taken),
        .trap          (trap),
        .mem_busy      (mem_busy),
        .wfi           (wfi),
        .irq_pending   (irq_pending),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .id_ex_stall   (id_ex_stall),
        .ex_mem_stall  (ex_mem_stall),
        .mem_wb_stall  (mem_wb_stall),
        .if_id_squash  (if_id_squash),
        .id_ex_squash  (id_ex_squash),
        .ex_mem_squash (ex_mem_squash),
        .mem_wb_squash (mem_wb_squash),
        .redirect      (redirect),
        .redirect_sel  (redirect_sel)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
        .perf_halt_cycles  (perf_halt_cycles)
`endif
    );

    // Input word:  {rst, if_busy, load_use, branch, trap, mem_busy, wfi, irq}
    // Output word: {pc_stall, 4x stall, 4x squash, redirect, redirect_sel}
    localparam logic [7:0]  I_IDLE = 8'b0_0000_000;
    localparam logic [7:0]  I_RST  = 8'b1_0000_000;
    localparam logic [7:0]  I_IFB  = 8'b0_1000_000;
    localparam logic [7:0]  I_LU   = 8'b0_0100_000;
    localparam logic [7:0]  I_BR   = 8'b0_0010_000;
    localparam logic [7:0]  I_TRAP = 8'b0_0001_000;
    localparam logic [7:0]  I_MB   = 8'b0_0000_100;
    localparam logic [7:0]  I_WFI  = 8'b0_0000_010;
    localparam logic [7:0]  I_IRQ  = 8'b0_0000_001;

    localparam logic [10:0] O_NONE = 11'b0_0000_0000_00;
    localparam logic [10:0] O_RST  = 11'b0_0000_1111_00;
    localparam logic [10:0] O_IFB  = 11'b1_0000_1000_00;
    localparam logic [10:0] O_LU   = 11'b1_1000_0100_00;
    localparam logic [10:0] O_BR   = 11'b0_0000_1100_10;
    localparam logic [10:0] O_TRAP = 11'b0_0000_1110_11;
    localparam logic [10:0] O_FLSH = 11'b0_0000_1000_00;
    localparam logic [10:0] O_MB   = 11'b1_1110_0001_00;
    localparam logic [10:0] O_MBFL = 11'b1_0110_1001_00;
    localparam logic [10:0] O_HALT = 11'b1_1100_0010_00;

    typedef struct {
        logic [7:0]  in;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    bit          m_halted = 1'b0;
    bit          m_flush  = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;
    logic [31:0] m_halt_cnt  = '0;

    function automatic void add(input logic [7:0] i, input logic [10:0] e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [10:0] dut_out();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                mem_wb_stall, if_id_squash, id_ex_squash, ex_mem_squash,
                mem_wb_squash, redirect, redirect_sel};
    endfunction

    task automatic apply(input logic [7:0] v);
        {rst, if_busy, load_use, branch_taken, trap, mem_busy, wfi,
         irq_pending} = v;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic model(input logic [7:0] v, output logic [10:0] e);
        logic r, ib, lu, br, tr, mb, wf, ir;
        bit   was_halted;
        {r, ib, lu, br, tr, mb, wf, ir} = v;
        was_halted = m_halted;
        e = O_NONE;
        if (r) begin
            e = O_RST;
            m_halted = 1'b0;
            m_flush  = 1'b0;
        end else if (mb) begin
            e = m_flush ? O_MBFL : O_MB;
            m_halted = 1'b0;
            m_flush  = 1'b0;
        end else if (m_flush) begin
            e = O_FLSH;
            m_flush = 1'b0;
        end else if (m_halted) begin
            if (ir) m_halted = 1'b0;
            else    e = O_HALT;
        end else if (tr) begin
            e = O_TRAP;
            m_flush = 1'b1;
        end else if (br) begin
            e = O_BR;
        end else if (wf && !ir) begin
            e = O_HALT;
            m_halted = 1'b1;
        end else if (lu) begin
            e = O_LU;
        end else if (ib) begin
            e = O_IFB;
        end
        if (r) begin
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            m_halt_cnt  = '0;
        end else begin
            m_stall_cnt = m_stall_cnt + 32'(e[10]);
            m_flush_cnt = m_flush_cnt + 32'(e[1]);
            m_halt_cnt  = m_halt_cnt + 32'(was_halted);
        end
    endtask

    task automatic cycle(input logic [7:0] v, input string name);
        logic [10:0] e;
        apply(v);
        @(negedge clk);
`ifdef PIPELINE_CTRL_PERF_EN
        check({name, "_pstall"}, perf_stall_cycles, m_stall_cnt);
        check({name, "_pflush"}, perf_flush_count, m_flush_cnt);
        check({name, "_phalt"}, perf_halt_cycles, m_halt_cnt);
`endif
        model(v, e);
        check(name, 32'(dut_out()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(I_RST);
        add(I_RST, O_RST);
        add(I_IDLE, O_NONE);
        add(I_LU, O_LU);
        add(I_IDLE, O_NONE);
        add(I_TRAP, O_TRAP);
        add(I_IDLE, O_FLSH);
        add(I_IDLE, O_NONE);
        for (int k = 0; k < 3; k++) add(I_MB | I_BR, O_MB);
        add(I_BR, O_BR);
        add(I_IDLE, O_NONE);
        for (int k = 0; k < 5; k++) add(I_WFI, O_HALT);
        add(I_WFI | I_IRQ, O_NONE);
        add(I_TRAP, O_TRAP);
        add(I_IDLE, O_FLSH);
        add(I_TRAP | I_BR, O_TRAP);
        add(I_IDLE, O_FLSH);
        add(I_MB, O_MB);
        add(I_RST | I_MB, O_RST);
        add(I_IDLE, O_NONE);
        add(I_WFI | I_IRQ, O_NONE);
        add(I_IFB, O_IFB);
        add(I_LU | I_IFB, O_LU);
        add(I_TRAP, O_TRAP);
        add(I_MB, O_MBFL);
        add(I_IDLE, O_NONE);
        add(I_WFI, O_HALT);
        add(I_MB, O_MB);
        add(I_WFI, O_HALT);
        add(I_IRQ, O_NONE);
        add(I_IDLE, O_NONE);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
            @(posedge clk);
            #1;
        end

        // halt accounting and reset out of MEM_WAIT
        cycle(I_RST, "h_rst");
        for (int k = 0; k < 5; k++) cycle(I_WFI, $sformatf("h_wfi%0d", k));
        cycle(I_WFI | I_IRQ, "h_wake");
        cycle(I_IDLE, "h_run");
`ifdef PIPELINE_CTRL_PERF_EN
        @(negedge clk);
        check("halt_eq5", perf_halt_cycles, 32'd5);
        @(posedge clk);
        #1;
`endif
        cycle(I_MB, "r_mb");
        cycle(I_MB | I_RST, "r_rst");
        cycle(I_BR, "r_after");

        cycle(I_RST, "rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] v;
            v[7] = ($urandom_range(0, 99) < 2);
            v[6] = ($urandom_range(0, 99) < 25);
            v[5] = ($urandom_range(0, 99) < 15);
            v[4] = ($urandom_range(0, 99) < 12);
            v[3] = ($urandom_range(0, 99) < 8);
            v[2] = ($urandom_range(0, 99) < 20);
            v[1] = ($urandom_range(0, 99) < 15);
            v[0] = ($urandom_range(0, 99) < 40);
            cycle(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
- REQ-001: Clock/reset SHALL be: one clock; reset is synchronous and active-high.
- REQ-002: clk  in  1  rising-edge clock for all state.
- REQ-003: rst  in  1  synchronous active-high reset.
- REQ-004: if_busy  in  1  instruction fetch not yet returned.
- REQ-005: load_use  in  1  ID instruction sources the destination of a load in EX.
- REQ-006: branch_taken  in  1  EX resolved a taken branch/jump.
- REQ-007: trap  in  1  EX raised exception or took interrupt.
- REQ-008: mem_busy  in  1  MEM-stage data access waiting.
- REQ-009: wfi  in  1  EX holds a WFI instruction.
- REQ-010: irq_pending  in  1  enabled interrupt pending.
- REQ-011: pc_stall  out  1  hold PC register.
- REQ-012: {if_id, id_ex, ex_mem, mem_wb}_stall  out  1 each  hold the named stage register.
- REQ-013: {if_id, id_ex, ex_mem, mem_wb}_squash  out  1 each  load a bubble into the named stage register.
- REQ-014: redirect  out  1  PC loads redirect target this cycle.
- REQ-015: redirect_sel  out  1  0 = branch target, 1 = trap vector.

Function
- REQ-016: Outputs SHALL be combinational from inputs and registered state; state SHALL update on the rising clk edge.
- REQ-017: FSM states SHALL be RUN, MEM_WAIT, TRAP_FLUSH, HALT.
- REQ-018: Event priority SHALL be mem_busy > trap > branch_taken > wfi > load_use > if_busy.
- REQ-019: mem_busy SHALL assert pc_stall, if_id/id_ex/ex_mem_stall, and mem_wb_squash; state becomes MEM_WAIT and remains there while mem_busy is set; all EX events SHALL be deferred.
- REQ-020: Leaving MEM_WAIT SHALL return to RUN; deferred EX events SHALL be acted on in the first cycle mem_busy is low.
- REQ-021: trap SHALL assert redirect, redirect_sel=1, and if_id/id_ex/ex_mem_squash; next state SHALL be TRAP_FLUSH.
- REQ-022: TRAP_FLUSH SHALL last exactly 1 cycle, assert if_id_squash, and return to RUN, or to MEM_WAIT if mem_busy is set.
- REQ-023: branch_taken SHALL assert redirect, redirect_sel=0, and if_id/id_ex_squash for 1 cycle; state stays RUN.
- REQ-024: wfi with irq_pending low SHALL enter HALT: pc_stall, if_id_stall, id_ex_stall, ex_mem_squash held.
- REQ-025: In HALT, irq_pending high SHALL return to RUN in the next cycle; the trap input then governs.
- REQ-026: wfi with irq_pending already high SHALL be a no-op.
- REQ-027: load_use SHALL assert pc_stall, if_id_stall, id_ex_squash for exactly 1 cycle.
- REQ-028: if_busy SHALL assert pc_stall and if_id_squash.
- REQ-029: A stall and a squash SHALL never both be asserted on the same register; squash wins.
- REQ-030: With no event in RUN, all stall, squash and redirect outputs SHALL be 0.

Reset
- REQ-031: While rst is high, all *_squash outputs SHALL be 1, all *_stall outputs 0, redirect 0, redirect_sel 0, and state RUN.
- REQ-032: rst asserted in any state SHALL abort it; no deferred event survives reset.

Configuration
- REQ-033: PIPELINE_CTRL_PERF_EN defined SHALL add 32-bit wrapping counters with outputs perf_stall_cycles, perf_flush_count, perf_halt_cycles; all reset to 0.
- REQ-034: perf_stall_cycles SHALL count cycles with pc_stall=1; perf_flush_count SHALL count redirect pulses; perf_halt_cycles SHALL count HALT cycles.
- REQ-035: Without PIPELINE_CTRL_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
- REQ-036: The FSM state enum SHALL live in package rv32 as rv32::pipe_ctrl_state_t.
- REQ-037: The redirect_sel encodings SHALL live in package rv32 as constants.
- REQ-038: Counters SHALL be implemented in one sub-module, pipe_perf_cnt, instantiated only under the macro.

Verification
- REQ-039: load_use=1 for 1 cycle -> pc_stall=1, if_id_stall=1, id_ex_squash=1 in that cycle only; all outputs 0 the next cycle.
- REQ-040: trap=1 -> redirect=1, redirect_sel=1, if_id/id_ex/ex_mem_squash=1; next cycle TRAP_FLUSH with if_id_squash=1 only; then RUN.
- REQ-041: mem_busy=1 for 3 cycles with branch_taken=1 throughout -> no redirect for 3 cycles; redirect=1, redirect_sel=0 in cycle 4.
- REQ-042: wfi=1, irq_pending=0 for 5 cycles, then irq_pending=1 -> HALT outputs for 5 cycles; RUN in the next cycle; perf_halt_cycles=5 with the macro defined.
- REQ-043: rst=1 during MEM_WAIT -> all squashes=1, stalls=0, state RUN the cycle after rst falls; perf counters=0.
- REQ-044: trap=1 and branch_taken=1 simultaneously -> redirect_sel=1, ex_mem_squash=1.
